// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding uart_tx through the uart_tx_en / uart_tx_busy handshake.
// Optional feature macro UART_TX_FIFO_FLUSH_EN adds a synchronous flush input.
module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
`ifdef UART_TX_FIFO_FLUSH_EN
    input  logic                  flush,
`endif
    input  logic                  wr_en,
    input  logic [7:0]            wr_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    input  logic                  ovf_clr,
    input  logic                  uart_tx_busy,
    output logic                  uart_tx_en,
    output logic [7:0]            uart_tx_data
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int LW    = DEPTH_LOG2 + 1;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2:0]   LVL_ONE  = LW'(1);
    localparam logic [DEPTH_LOG2:0]   LVL_FULL = LW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    state_t                state;
    state_t                state_next;
    logic                  pop;
    logic                  push;
    logic                  drop;
    logic                  flush_i;

`ifdef UART_TX_FIFO_FLUSH_EN
    assign flush_i = flush;
`else
    assign flush_i = 1'b0;
`endif

    assign full  = (level == LVL_FULL);
    assign empty = (level == '0);

    // A same-cycle pop frees a slot, so a push into a full FIFO is still accepted.
    assign push = wr_en && (!full || pop) && !flush_i;
    assign drop = wr_en && full && !pop && !flush_i;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        uart_tx_en = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty && !uart_tx_busy) begin
                    pop        = 1'b1;
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                uart_tx_en = 1'b1;
                state_next = uart_tx_busy ? S_DONE : S_WAIT;
            end
            S_WAIT: begin
                if (uart_tx_busy) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (!uart_tx_busy) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            overflow     <= 1'b0;
            uart_tx_data <= 8'h00;
        end else begin
            if (flush_i) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_ONE;
                end
                if (push && !pop) begin
                    level <= level + LVL_ONE;
                end else if (pop && !push) begin
                    level <= level - LVL_ONE;
                end
            end
            // The popped byte stays on uart_tx_data until the next pop, even across a flush.
            if (pop) begin
                uart_tx_data <= mem[rd_ptr];
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule
